uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 105 ++++++++++
 tb/tb_uart_tx_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO with a drain FSM that feeds uart_tx via START/BUSY
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  WR_EN,
    input  logic [7:0]            WR_DATA,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  OVERFLOW,
    input  logic                  CLR_OVF,
    output logic                  IDLE,
    output logic                  TX_START,
    output logic [7:0]            TX_DATA,
    input  logic                  TX_BUSY
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_START     = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;
    logic [DEPTH_LOG2:0]   cnt;
    logic [1:0]            state;
    logic [7:0]            tx_data;
    logic                  ovf;
    logic                  wr_acc;
    logic                  pop;

    assign FULL     = (cnt == CNT_FULL);
    assign EMPTY    = (cnt == '0);
    assign COUNT    = cnt;
    assign OVERFLOW = ovf;
    assign TX_START = (state == S_START);
    assign TX_DATA  = tx_data;
    assign IDLE     = EMPTY && (state == S_IDLE);

    assign wr_acc = WR_EN && !FULL;
    assign pop    = (state == S_IDLE) && !EMPTY;

    // Storage is deliberately left unreset.
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wp] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            state   <= S_IDLE;
            tx_data <= 8'h00;
            ovf     <= 1'b0;
        end else begin
            if (wr_acc) begin
                wp <= wp + PTR_ONE;
            end
            if (pop) begin
                rp <= rp + PTR_ONE;
            end
            if (wr_acc && !pop) begin
                cnt <= cnt + CNT_ONE;
            end else if (pop && !wr_acc) begin
                cnt <= cnt - CNT_ONE;
            end

            // A rejected write flags overflow even if a pop frees space this cycle.
            if (WR_EN && FULL) begin
                ovf <= 1'b1;
            end else if (CLR_OVF) begin
                ovf <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        tx_data <= mem[rp];
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (TX_BUSY) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!TX_BUSY) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed vector table plus uart_tx model for uart_tx_fifo
module tb_uart_tx_fifo;
    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       clr_ovf;
    logic       idle;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en), .WR_DATA(wr_data),
        .FULL(full), .EMPTY(empty), .COUNT(count), .OVERFLOW(overflow),
        .CLR_OVF(clr_ovf), .IDLE(idle), .TX_START(tx_start),
        .TX_DATA(tx_data), .TX_BUSY(tx_busy)
    );

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       busy;
        logic       clr;
        logic [4:0] cnt;
        logic       emp;
        logic       ful;
        logic       st;
        logic [7:0] dat;
        logic       idl;
        logic       ovf;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         max_cnt = 0;
    logic       model_en = 1'b0;
    logic       model_rand = 1'b0;
    int         model_lat = 1;
    int         model_hold = 20;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (int'(count) > max_cnt) max_cnt = int'(count);
    end

    // uart_tx stand-in: captures TX_DATA on START, raises BUSY after a latency, holds it.
    initial begin : uart_model
        int lat;
        int hold;
        forever begin
            @(posedge clk); #2;
            if (model_en && tx_start && !tx_busy) begin
                rx_q.push_back(tx_data);
                lat  = model_rand ? int'($urandom_range(0, 5)) : model_lat;
                hold = model_rand ? int'($urandom_range(1, 3)) : model_hold;
                repeat (lat) begin @(posedge clk); #2; end
                tx_busy = 1'b1;
                repeat (hold) begin @(posedge clk); #2; end
                tx_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr_byte(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        cyc(1);
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int n, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (rx_q.size() >= n && idle) break;
            cyc(1);
        end
        chk("drain_done", {31'd0, (rx_q.size() >= n && idle)}, 32'd1);
    endtask

    task automatic cmp_rx(input string name);
        chk({name, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            if (rx_q[i] !== exp_q[i]) chk($sformatf("%s_byte%0d", name, i), rx_q[i], exp_q[i]);
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0; tx_busy = 1'b0;
        #1;
        chk("reset_outs", {count, empty, full, tx_start, tx_data, idle, overflow},
            {5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        #20 rst_n = 1'b1;
        cyc(2);

        // wr, wd, busy, clr | cnt, empty, full, start, data, idle, ovf
        vecs.push_back('{1'b1, 8'h5A, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 8'h77, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h88, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 8'h88, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h88, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h88, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 8'h88, 1'b1, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            wr_en = vecs[i].wr; wr_data = vecs[i].wd; tx_busy = vecs[i].busy; clr_ovf = vecs[i].clr;
            cyc(1);
            chk($sformatf("vec%0d", i), {count, empty, full, tx_start, tx_data, idle, overflow},
                {vecs[i].cnt, vecs[i].emp, vecs[i].ful, vecs[i].st, vecs[i].dat, vecs[i].idl, vecs[i].ovf});
        end
        wr_en = 1'b0; tx_busy = 1'b0; clr_ovf = 1'b0;

        // Single byte through the uart model.
        model_en = 1'b1; model_lat = 1; model_hold = 20; rx_q.delete();
        wr_byte(8'h5A);
        chk("single_n1_start", {31'd0, tx_start}, 32'd0);
        cyc(1);
        chk("single_n2", {tx_start, tx_data}, {1'b1, 8'h5A});
        cyc(1);
        chk("single_n3_start", {31'd0, tx_start}, 32'd1);
        cyc(1);
        chk("single_n4_start", {31'd0, tx_start}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (!tx_busy) break;
            cyc(1);
        end
        cyc(1);
        chk("single_idle", {31'd0, idle}, 32'd1);
        exp_q = '{8'h5A};
        cmp_rx("single");

        // Burst of 17: one byte pops early so the 17th is accepted.
        rx_q.delete(); exp_q.delete();
        for (int i = 0; i <= 16; i++) begin
            exp_q.push_back(8'(i));
            wr_byte(8'(i));
        end
        chk("burst_flags", {count, full, overflow}, {5'd16, 1'b1, 1'b0});
        wait_drain(17, 2000);
        cmp_rx("burst");

        // Overflow with the drain stalled behind a held BUSY.
        model_en = 1'b0; tx_busy = 1'b1; rx_q.delete(); exp_q.delete();
        for (int i = 0; i < 18; i++) wr_byte(8'h80 + 8'(i));
        chk("ovf_flags", {count, full, overflow, tx_data}, {5'd16, 1'b1, 1'b1, 8'h80});
        cyc(5);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        wr_en = 1'b1; wr_data = 8'hEE; clr_ovf = 1'b1;
        cyc(1);
        wr_en = 1'b0;
        chk("ovf_set_wins", {count, overflow}, {5'd16, 1'b1});
        cyc(1);
        clr_ovf = 1'b0;
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        for (int i = 1; i <= 16; i++) exp_q.push_back(8'h80 + 8'(i));
        model_en = 1'b1; model_hold = 3; tx_busy = 1'b0;
        wait_drain(16, 1000);
        cmp_rx("ovf");

        // Reset while waiting for BUSY to fall.
        model_en = 1'b0;
        wr_byte(8'h41); wr_byte(8'h42); wr_byte(8'h43);
        tx_busy = 1'b1;
        cyc(1);
        chk("mid_wait", {tx_start, tx_data, count}, {1'b0, 8'h41, 5'd2});
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset", {count, empty, tx_start, tx_data, idle, full, overflow},
            {5'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0});
        #3 rst_n = 1'b1; tx_busy = 1'b0;
        begin
            int hi = 0;
            for (int i = 0; i < 100; i++) begin
                cyc(1);
                if (tx_start) hi++;
            end
            chk("post_reset_quiet", hi, 0);
        end

        // Random bursts and gaps against a scoreboard.
        model_en = 1'b1; model_rand = 1'b1; rx_q.delete(); exp_q.delete();
        begin
            int sent = 0;
            while (sent < 1000) begin
                int b = int'($urandom_range(1, 8));
                if (sent + b > 1000) b = 1000 - sent;
                for (int k = 0; k < b; k++) begin
                    logic [7:0] d = 8'($urandom_range(0, 255));
                    exp_q.push_back(d);
                    wr_byte(d);
                end
                sent += b;
                cyc(b * 12 + int'($urandom_range(0, 10)));
            end
        end
        wait_drain(1000, 5000);
        cmp_rx("rand");
        chk("rand_ovf", {31'd0, overflow}, 32'd0);
        chk("rand_wraps", {31'd0, (rx_q.size() / 16 >= 60)}, 32'd1);
        chk("max_count", {31'd0, (max_cnt <= 16)}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
